// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator: structure selectors, a table of
// primitive polynomials and the single-step next-state function.
package lfsr_pkg;

    localparam int LFSR_FIB = 0;
    localparam int LFSR_GAL = 1;

    // Primitive polynomials for widths 3..32. Bit k is the coefficient of x^k,
    // and the x^width term is implied. Widths outside the table return 0.
    function automatic logic [31:0] default_poly(input int width);
        logic [31:0] p;
        case (width)
            3:       p = 32'h0000_0005;
            4:       p = 32'h0000_0009;
            5:       p = 32'h0000_0009;
            6:       p = 32'h0000_0021;
            7:       p = 32'h0000_0041;
            8:       p = 32'h0000_0071;
            9:       p = 32'h0000_0021;
            10:      p = 32'h0000_0081;
            11:      p = 32'h0000_0201;
            12:      p = 32'h0000_0053;
            13:      p = 32'h0000_001B;
            14:      p = 32'h0000_002B;
            15:      p = 32'h0000_4001;
            16:      p = 32'h0000_6801;
            17:      p = 32'h0000_4001;
            18:      p = 32'h0000_0801;
            19:      p = 32'h0000_0047;
            20:      p = 32'h0002_0001;
            21:      p = 32'h0008_0001;
            22:      p = 32'h0020_0001;
            23:      p = 32'h0004_0001;
            24:      p = 32'h00C2_0001;
            25:      p = 32'h0040_0001;
            26:      p = 32'h0000_0047;
            27:      p = 32'h0000_0027;
            28:      p = 32'h0200_0001;
            29:      p = 32'h0800_0001;
            30:      p = 32'h0000_0053;
            31:      p = 32'h1000_0001;
            32:      p = 32'h0040_0007;
            default: p = 32'h0000_0000;
        endcase
        return p;
    endfunction

    // One LFSR step on the low 'width' bits; bits at and above 'width' are
    // returned as zero so the caller can truncate freely.
    function automatic logic [31:0] lfsr_step(input logic [31:0] state,
                                              input logic [31:0] poly,
                                              input int          mode,
                                              input int          width);
        logic [31:0] nxt;
        logic        msb;
        logic        fb;
        msb = state[width-1];
        if (mode == LFSR_FIB) begin
            // Feedback is the MSB XORed with the tap below each set coefficient.
            fb = msb;
            for (int k = 1; k < 32; k++) begin
                if (k < width && poly[k]) fb = fb ^ state[k-1];
            end
            nxt = {state[30:0], fb};
        end else begin
            nxt = {state[30:0], 1'b0} ^ (msb ? poly : 32'h0);
        end
        for (int i = 0; i < 32; i++) begin
            if (i >= width) nxt[i] = 1'b0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational chain of STEPS single LFSR steps, so one advance can move the
// sequence forward by several positions in a single cycle.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int             WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(default_poly(WIDTH)),
    parameter int             MODE  = LFSR_FIB,
    parameter int             STEPS = 1
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next
);

    logic [WIDTH-1:0] chain [0:STEPS];

    assign chain[0] = state;

    for (genvar i = 0; i < STEPS; i++) begin : g_step
        assign chain[i+1] = WIDTH'(lfsr_step(32'(chain[i]), 32'(POLY), MODE, WIDTH));
    end

    assign next = chain[STEPS];

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR pattern source with a valid/ready output stream, zero-seed
// substitution and a pulse each time the sequence returns to its seed.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] POLY         = WIDTH'(default_poly(WIDTH)),
    parameter int               MODE         = LFSR_FIB,
    parameter int               STEPS        = 1,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             wrap,
    output logic             seed_err
);

    // Parameter legality is enforced at elaboration time.
    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be in 3..32");
    end
    if (POLY[0] != 1'b1) begin : g_bad_poly
        $error("lfsr_gen: POLY[0] must be 1");
    end
    if (MODE != LFSR_FIB && MODE != LFSR_GAL) begin : g_bad_mode
        $error("lfsr_gen: MODE must be 0 or 1");
    end
    if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
        $error("lfsr_gen: STEPS must be in 1..WIDTH");
    end
    if (SEED_DEFAULT == '0) begin : g_bad_seed
        $error("lfsr_gen: SEED_DEFAULT must be non-zero");
    end

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] ref_seed;
    logic [WIDTH-1:0] next;
    logic [WIDTH-1:0] seed_safe;
    logic             adv;

    lfsr_next #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .MODE  (MODE),
        .STEPS (STEPS)
    ) u_next (
        .state (state),
        .next  (next)
    );

    // An all-zero seed would lock the register, so it is replaced by the default.
    assign seed_safe = (seed == '0) ? SEED_DEFAULT : seed;

    // Advance only when not loading and the current word has been taken or was never valid.
    assign adv = enb & ~load & (~out_valid | out_ready);

    // State, reference seed and stream handshake; load wins over advance, advance over drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SEED_DEFAULT;
            ref_seed  <= SEED_DEFAULT;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            seed_err  <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            seed_err <= 1'b0;
            if (load) begin
                state     <= seed_safe;
                ref_seed  <= seed_safe;
                out_valid <= 1'b0;
                seed_err  <= (seed == '0);
            end else if (adv) begin
                state     <= next;
                out_valid <= 1'b1;
                wrap      <= (next == ref_seed);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_data = state;

endmodule
